// File: rtl/mips_pkg.sv
// Shared MIPS control types: state encodings seen by the state controller and the decoder.
package mips_pkg;

  localparam logic [1:0] FETCH_ENC = 2'b00;
  localparam logic [1:0] EXEC1_ENC = 2'b01;
  localparam logic [1:0] EXEC2_ENC = 2'b10;
  localparam logic [1:0] HALT_ENC  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = FETCH_ENC,
    EXEC1 = EXEC1_ENC,
    EXEC2 = EXEC2_ENC,
    HALT  = HALT_ENC
  } state_t;

  localparam int RETIRED_W = 32;

endpackage

// File: rtl/mips_state_ctrl_if.sv
// Decoder <-> state controller signal bundle; master is the decoder/memory side, slave is the controller.
interface mips_state_ctrl_if;
  import mips_pkg::*;

  logic                 halt_req;
  logic                 extra;
  logic                 mem_read;
  logic                 mem_write;
  logic                 waitrequest;
  logic                 md_start;
  logic                 md_done;
  state_t               state;
  logic                 ir_en;
  logic                 pc_en;
  logic                 stall;
  logic                 active;
  logic [RETIRED_W-1:0] retired;

  modport master (
    output halt_req, extra, mem_read, mem_write, waitrequest, md_start, md_done,
    input  state, ir_en, pc_en, stall, active, retired
  );

  modport slave (
    input  halt_req, extra, mem_read, mem_write, waitrequest, md_start, md_done,
    output state, ir_en, pc_en, stall, active, retired
  );

endinterface

// File: rtl/mips_state_ctrl.sv
// Multicycle MIPS sequencer: FETCH/EXEC1/EXEC2/HALT with registered state, active and retired count.
// Strobes are combinational (zero latency); waitrequest and mult/div hold the current state one cycle each.
module mips_state_ctrl
  import mips_pkg::*;
#(
  parameter logic [RETIRED_W-1:0] RETIRED_RST = '0
) (
  input logic             clk,
  input logic             reset,
  mips_state_ctrl_if.slave bus
);

  state_t               state_q, state_d;
  logic                 md_pending_q, md_pending_d;
  logic                 md_served_q, md_served_d;
  logic                 active_q, active_d;
  logic [RETIRED_W-1:0] retired_q;
  logic                 retire;
  logic                 ir_en_c, pc_en_c, stall_c;
  logic                 mem_hold, md_begin, md_hold;

  always_comb begin
    state_d      = state_q;
    md_pending_d = md_pending_q;
    md_served_d  = md_served_q;
    active_d     = active_q;
    ir_en_c      = 1'b0;
    pc_en_c      = 1'b0;
    stall_c      = 1'b0;
    retire       = 1'b0;
    mem_hold     = (bus.mem_read | bus.mem_write) & bus.waitrequest;
    // md_served blocks a still-high md_start from re-arming the unit within one instruction
    md_begin     = bus.md_start & ~md_pending_q & ~md_served_q;
    md_hold      = md_begin | (md_pending_q & ~bus.md_done);

    case (state_q)
      FETCH: begin
        if (bus.halt_req) begin
          state_d  = HALT;
          active_d = 1'b0;
        end else if (bus.mem_read & bus.waitrequest) begin
          stall_c = 1'b1;
        end else begin
          ir_en_c = 1'b1;
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        if (md_begin) begin
          md_pending_d = 1'b1;
          md_served_d  = 1'b1;
        end else if (md_pending_q & bus.md_done) begin
          md_pending_d = 1'b0;
        end
        if (mem_hold | md_hold) begin
          stall_c = 1'b1;
        end else begin
          md_served_d = 1'b0;
          if (bus.extra) begin
            state_d = EXEC2;
          end else begin
            state_d = FETCH;
            pc_en_c = 1'b1;
            retire  = 1'b1;
          end
        end
      end
      EXEC2: begin
        if (bus.mem_read & bus.waitrequest) begin
          stall_c = 1'b1;
        end else begin
          state_d = FETCH;
          pc_en_c = 1'b1;
          retire  = 1'b1;
        end
      end
      default: ;
    endcase

    // reset abandons the instruction: no strobes and no retirement in the reset cycle
    if (reset) begin
      ir_en_c = 1'b0;
      pc_en_c = 1'b0;
      stall_c = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      md_pending_q <= 1'b0;
      md_served_q  <= 1'b0;
      active_q     <= 1'b1;
      retired_q    <= RETIRED_RST;
    end else begin
      state_q      <= state_d;
      md_pending_q <= md_pending_d;
      md_served_q  <= md_served_d;
      active_q     <= active_d;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign bus.state   = state_q;
  assign bus.ir_en   = ir_en_c;
  assign bus.pc_en   = pc_en_c;
  assign bus.stall   = stall_c;
  assign bus.active  = active_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/mips_state_ctrl.md
MIPS_STATE_CTRL -- requirements
Module: mips_state_ctrl

Interface
REQ-001 Parameter: FETCH_ENC = 2'b00, EXEC1_ENC = 2'b01, EXEC2_ENC = 2'b10, HALT_ENC = 2'b11. These are the state encodings driven to the decoder.
REQ-002 Port: clk, input, 1 bit, single clock. All state updates on rising edge.
REQ-003 Port: reset, input, 1 bit. Reset is synchronous and active-high.
REQ-004 Port: halt_req, input, 1 bit, decoder Halt (PC == 0).
REQ-005 Port: extra, input, 1 bit, decoder Extra: the instruction needs EXEC2 (loads).
REQ-006 Port: mem_read, input, 1 bit, decoder MemRead for the current state.
REQ-007 Port: mem_write, input, 1 bit, decoder MemWrite for the current state.
REQ-008 Port: waitrequest, input, 1 bit, memory bus stall.
REQ-009 Port: md_start, input, 1 bit, mult/div instruction present in EXEC1.
REQ-010 Port: md_done, input, 1 bit, mult/div unit result ready.
REQ-011 Port: state, output, 2 bits, registered current state, to the decoder.
REQ-012 Port: ir_en, output, 1 bit, instruction register load enable.
REQ-013 Port: pc_en, output, 1 bit, PC update enable; ANDed with decoder CntEn outside this block.
REQ-014 Port: stall, output, 1 bit, current cycle held by waitrequest or mult/div.
REQ-015 Port: active, output, 1 bit, CPU running.
REQ-016 Port: retired, output, 32 bits, count of completed instructions.

Function
REQ-017 FETCH, halt_req high: next state HALT; ir_en = 0. halt_req has priority over waitrequest.
REQ-018 FETCH, halt_req low, mem_read & waitrequest: stay in FETCH; stall = 1; ir_en = 0.
REQ-019 FETCH, otherwise: ir_en = 1; next state EXEC1.
REQ-020 EXEC1 holds while either condition is true:
- (mem_read | mem_write) & waitrequest, or
- md_pending is set and md_done is low.
  While held, stall = 1 and pc_en = 0.
REQ-021 md_pending is an internal flag:
- Set on the first EXEC1 cycle in which md_start is high.
- Cleared in the cycle md_done is high while it is set.
- md_done is ignored while md_pending is clear, including when it arrives in the same cycle as md_start.
REQ-022 EXEC1, not held, extra high: next state EXEC2; pc_en = 0.
REQ-023 EXEC1, not held, extra low: next state FETCH; pc_en = 1; retired increments.
REQ-024 EXEC2, mem_read & waitrequest: stay in EXEC2; stall = 1.
REQ-025 EXEC2, otherwise: next state FETCH; pc_en = 1; retired increments.
REQ-026 HALT is absorbing until reset.
- active is cleared on the transition into HALT.
- All strobes are 0 in HALT: ir_en, pc_en, stall.
REQ-027 ir_en, pc_en and stall are combinational from the registered state and the current inputs. They have zero-cycle latency.
REQ-028 retired wraps 0xFFFFFFFF -> 0x00000000, with no sticky flag.
REQ-029 pc_en and ir_en are never high in the same cycle.
REQ-030 Minimum instruction latency:
- 2 cycles without EXEC2 (FETCH, EXEC1).
- 3 cycles with EXEC2.
- Each waitrequest or mult/div cycle adds exactly one cycle.

Reset
REQ-031 On a reset edge, the following values are loaded:
- state = FETCH
- md_pending = 0
- retired = 0
- active = 1
REQ-032 Reset asserted mid-instruction, in any state including HALT, abandons the instruction.
- No pc_en pulse and no retired increment occur in the reset cycle.
- FETCH resumes in the first cycle after reset is released.
REQ-033 While reset is high, outputs are forced: ir_en = 0, pc_en = 0, stall = 0.

Structure
REQ-034 The state encodings become a state_t enum in the shared package mips_pkg, imported by both this block and the decoder.
REQ-035 The block is flat: one registered-state process and one next-state/strobe combinational process. A sub-module is not warranted.

Verification
REQ-036 Reset, then halt_req = 0, waitrequest = 0, extra = 0 for 6 cycles -> state sequence 00,01,00,01,00,01; ir_en on cycles 1,3,5; pc_en on cycles 2,4,6; retired = 3.
REQ-037 Load (extra = 1, mem_read = 1) with waitrequest high for 2 EXEC2 cycles -> 01,10,10,10,00; stall = 1 on 2 cycles; single pc_en; retired += 1.
REQ-038 md_start in EXEC1, md_done 4 cycles later -> EXEC1 held 4 cycles with stall = 1, then FETCH with pc_en; md_done pulsed with no start -> ignored.
REQ-039 FETCH with halt_req = 1 and waitrequest = 1 -> HALT next cycle, active = 0, no ir_en; state remains 11 for 10 cycles.
REQ-040 Preload retired = 0xFFFFFFFF (run 2^32 retirements in formal/forced sim) and retire one more -> 0x00000000.
REQ-041 Reset asserted in EXEC2 with waitrequest high -> next state 00, retired unchanged at 0, md_pending cleared, active = 1.
